// File: rtl/gnr_attractor_ctrl.sv
// Floyd-style attractor search sequencer for one bank of dual-state Boolean network nodes.
// Drives load/step strobes into the node bank and measures transient length and period.
module gnr_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic               timeout,
  output logic [CNT_W-1:0]   steps,
  output logic [CNT_W-1:0]   period,
  output logic [N_NODES-1:0] attractor,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PERIOD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_TWO = CNT_W'(2);

  state_t           r_state;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] r_period_cnt;

  logic w_vec_eq;
  logic w_run_match;
  logic w_period_match;
  logic w_step_lim;
  logic w_period_lim;

  // Counts 0 and 1 are skipped: after a single pulse tortoise and hare agree trivially.
  assign w_vec_eq       = (s0_vec == s1_vec);
  assign w_run_match    = (r_step_cnt >= LP_TWO) && w_vec_eq;
  assign w_period_match = (r_period_cnt >= LP_ONE) && w_vec_eq;
  assign w_step_lim     = (r_step_cnt == LP_MAX);
  assign w_period_lim   = (r_period_cnt == LP_MAX);
  assign dbg_state      = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_step_cnt   <= '0;
      r_period_cnt <= '0;
      reset_nos    <= 1'b0;
      init_state   <= '0;
      start_s0     <= 1'b0;
      start_s1     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      timeout      <= 1'b0;
      steps        <= '0;
      period       <= '0;
      attractor    <= '0;
    end else begin
      reset_nos <= 1'b0;
      start_s0  <= 1'b0;
      start_s1  <= 1'b0;
      done      <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              init_state   <= init_vec;
              found        <= 1'b0;
              timeout      <= 1'b0;
              steps        <= '0;
              period       <= '0;
              attractor    <= '0;
              r_step_cnt   <= '0;
              r_period_cnt <= '0;
              reset_nos    <= 1'b1;
              busy         <= 1'b1;
              r_state      <= S_LOAD;
            end
          end
          S_LOAD: begin
            r_state <= S_RUN;
          end
          S_RUN: begin
            if (w_run_match) begin
              attractor <= s0_vec;
              steps     <= r_step_cnt;
              r_state   <= S_PERIOD;
            end else if (w_step_lim) begin
              timeout <= 1'b1;
              steps   <= r_step_cnt;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              start_s0   <= 1'b1;
              start_s1   <= 1'b1;
              r_step_cnt <= r_step_cnt + LP_ONE;
            end
          end
          S_PERIOD: begin
            // Tortoise stays parked on the attractor; only the hare walks the cycle.
            if (w_period_match) begin
              found   <= 1'b1;
              period  <= r_period_cnt;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else if (w_period_lim) begin
              timeout <= 1'b1;
              period  <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              start_s1     <= 1'b1;
              r_period_cnt <= r_period_cnt + LP_ONE;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl: node-bank model, expected-result queues and done-triggered monitors.
module tb_gnr_attractor_ctrl;
  localparam int NN = 2;
  localparam int CW = 16;
  localparam int EW = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start_a = 1'b0;
  logic          start_b = 1'b0;
  logic          abort = 1'b0;
  logic [NN-1:0] init_vec = '0;
  int            net_mode = 0;

  logic [NN-1:0] a_s0_vec, a_s1_vec, a_init_state, a_attractor;
  logic          a_reset_nos, a_start_s0, a_start_s1, a_busy, a_done, a_found, a_timeout;
  logic [CW-1:0] a_steps, a_period;
  logic [2:0]    a_dbg;
  logic [NN-1:0] b_s0_vec, b_s1_vec, b_init_state, b_attractor;
  logic          b_reset_nos, b_start_s0, b_start_s1, b_busy, b_done, b_found, b_timeout;
  logic [CW-1:0] b_steps, b_period;
  logic [2:0]    b_dbg;

  gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(1000)) u_dut_a (
    .clk(clk), .rst(rst_n), .start(start_a), .abort(abort), .init_vec(init_vec),
    .s0_vec(a_s0_vec), .s1_vec(a_s1_vec), .reset_nos(a_reset_nos), .init_state(a_init_state),
    .start_s0(a_start_s0), .start_s1(a_start_s1), .busy(a_busy), .done(a_done),
    .found(a_found), .timeout(a_timeout), .steps(a_steps), .period(a_period),
    .attractor(a_attractor), .dbg_state(a_dbg)
  );

  gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(3)) u_dut_b (
    .clk(clk), .rst(rst_n), .start(start_b), .abort(abort), .init_vec(init_vec),
    .s0_vec(b_s0_vec), .s1_vec(b_s1_vec), .reset_nos(b_reset_nos), .init_state(b_init_state),
    .start_s0(b_start_s0), .start_s1(b_start_s1), .busy(b_busy), .done(b_done),
    .found(b_found), .timeout(b_timeout), .steps(b_steps), .period(b_period),
    .attractor(b_attractor), .dbg_state(b_dbg)
  );

  int tests = 0;
  int failed = 0;
  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NN-1:0] f_node(input logic [NN-1:0] x);
    return (net_mode != 0) ? ~x : x;
  endfunction

  // Record layout: latency, s1 pulses, s0 pulses, found, timeout, steps, period, attractor.
  function automatic logic [EW-1:0] pack_exp(input int lat, input int n1, input int n0,
      input logic fnd, input logic tmo, input int st, input int per, input logic [NN-1:0] att);
    return {8'(lat), 8'(n1), 8'(n0), fnd, tmo, CW'(st), CW'(per), att};
  endfunction

  // Node bank models: hare steps on every pulse, tortoise on odd-numbered pulses.
  logic [NN-1:0] a_r0 = '0, a_r1 = '0, b_r0 = '0, b_r1 = '0;
  int a_p0 = 0, b_p0 = 0;
  assign a_s0_vec = a_r0;
  assign a_s1_vec = a_r1;
  assign b_s0_vec = b_r0;
  assign b_s1_vec = b_r1;

  always @(negedge clk) begin
    if (a_reset_nos) begin
      a_r0 = a_init_state; a_r1 = a_init_state; a_p0 = 0;
    end else begin
      if (a_start_s1) a_r1 = f_node(a_r1);
      if (a_start_s0) begin
        a_p0++;
        if (a_p0 % 2 == 1) a_r0 = f_node(a_r0);
      end
    end
    if (b_reset_nos) begin
      b_r0 = b_init_state; b_r1 = b_init_state; b_p0 = 0;
    end else begin
      if (b_start_s1) b_r1 = f_node(b_r1);
      if (b_start_s0) begin
        b_p0++;
        if (b_p0 % 2 == 1) b_r0 = f_node(b_r0);
      end
    end
  end

  int a_n0 = 0, a_n1 = 0, a_lat = 0;
  int b_n0 = 0, b_n1 = 0, b_lat = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (a_reset_nos) begin a_n0 = 0; a_n1 = 0; a_lat = 0; end
    else begin a_n0 += int'(a_start_s0); a_n1 += int'(a_start_s1); a_lat++; end
    if (a_done) begin
      if (exp_a_q.size() == 0) chk("a_unexpected_done", 64'd1, 64'd0);
      else begin
        e = exp_a_q.pop_front();
        chk("a_latency", 64'(a_lat), 64'(e[59:52]));
        chk("a_s1_pulses", 64'(a_n1), 64'(e[51:44]));
        chk("a_s0_pulses", 64'(a_n0), 64'(e[43:36]));
        chk("a_found", 64'(a_found), 64'(e[35]));
        chk("a_timeout", 64'(a_timeout), 64'(e[34]));
        chk("a_steps", 64'(a_steps), 64'(e[33:18]));
        chk("a_period", 64'(a_period), 64'(e[17:2]));
        chk("a_attractor", 64'(a_attractor), 64'(e[1:0]));
        chk("a_busy_at_done", 64'(a_busy), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (b_reset_nos) begin b_n0 = 0; b_n1 = 0; b_lat = 0; end
    else begin b_n0 += int'(b_start_s0); b_n1 += int'(b_start_s1); b_lat++; end
    if (b_done) begin
      if (exp_b_q.size() == 0) chk("b_unexpected_done", 64'd1, 64'd0);
      else begin
        e = exp_b_q.pop_front();
        chk("b_latency", 64'(b_lat), 64'(e[59:52]));
        chk("b_s1_pulses", 64'(b_n1), 64'(e[51:44]));
        chk("b_s0_pulses", 64'(b_n0), 64'(e[43:36]));
        chk("b_found", 64'(b_found), 64'(e[35]));
        chk("b_timeout", 64'(b_timeout), 64'(e[34]));
        chk("b_steps", 64'(b_steps), 64'(e[33:18]));
        chk("b_period", 64'(b_period), 64'(e[17:2]));
        chk("b_attractor", 64'(b_attractor), 64'(e[1:0]));
      end
    end
  end

  task automatic do_start(input bit sel, input logic [NN-1:0] iv);
    @(posedge clk); #1;
    init_vec = iv;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    chk("load_strobe_high", 64'(sel ? b_reset_nos : a_reset_nos), 64'd1);
    chk("init_state_latched", 64'(sel ? b_init_state : a_init_state), 64'(iv));
    @(negedge clk);
    chk("load_strobe_one_cycle", 64'(sel ? b_reset_nos : a_reset_nos), 64'd0);
  endtask

  task automatic wait_done(input bit sel, input int budget);
    int n = 0;
    while (!(sel ? b_done : a_done) && n < budget) begin
      @(negedge clk); n++;
    end
    if (!(sel ? b_done : a_done)) chk("done_wait_budget", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_a", 64'({a_reset_nos, a_start_s0, a_start_s1, a_busy, a_done, a_found,
        a_timeout, a_steps, a_period, a_attractor, a_init_state, a_dbg}), 64'd0);
    chk("reset_outputs_b", 64'({b_reset_nos, b_start_s0, b_start_s1, b_busy, b_done, b_found,
        b_timeout, b_steps, b_period, b_attractor, b_init_state, b_dbg}), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Identity network.
    net_mode = 0;
    exp_a_q.push_back(pack_exp(6, 3, 2, 1'b1, 1'b0, 2, 1, 2'b01));
    do_start(1'b0, 2'b01);
    chk("busy_while_running", 64'(a_busy), 64'd1);
    wait_done(1'b0, 50);

    // Toggle network, with a start pulse issued while busy.
    net_mode = 1;
    exp_a_q.push_back(pack_exp(9, 6, 4, 1'b1, 1'b0, 4, 2, 2'b00));
    do_start(1'b0, 2'b00);
    @(posedge clk); #1 init_vec = 2'b10; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    chk("busy_start_ignored_init", 64'(a_init_state), 64'd0);
    chk("busy_start_no_load", 64'(a_reset_nos), 64'd0);
    wait_done(1'b0, 50);

    // Step limit reached on the short-limit instance.
    exp_b_q.push_back(pack_exp(5, 3, 3, 1'b0, 1'b1, 3, 0, 2'b00));
    do_start(1'b1, 2'b00);
    wait_done(1'b1, 50);

    // Abort mid-RUN, then a clean rerun.
    do_start(1'b0, 2'b00);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(a_busy), 64'd0);
    chk("abort_strobes", 64'({a_reset_nos, a_start_s0, a_start_s1, a_done}), 64'd0);
    chk("abort_state_idle", 64'(a_dbg), 64'd0);
    repeat (12) @(negedge clk);
    exp_a_q.push_back(pack_exp(9, 6, 4, 1'b1, 1'b0, 4, 2, 2'b00));
    do_start(1'b0, 2'b00);
    wait_done(1'b0, 50);

    // Asynchronous reset while the hare is stepping in PERIOD.
    do_start(1'b0, 2'b00);
    begin
      int n = 0;
      while (!(a_dbg == 3'd3 && a_start_s1) && n < 50) begin
        @(negedge clk); n++;
      end
      chk("reached_period", 64'(a_dbg == 3'd3 && a_start_s1), 64'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({a_reset_nos, a_start_s0, a_start_s1, a_busy, a_done, a_found,
        a_timeout, a_steps, a_period, a_attractor, a_init_state}), 64'd0);
    chk("async_rst_state", 64'(a_dbg), 64'd0);
    #2 rst_n = 1'b1;
    net_mode = 0;
    exp_a_q.push_back(pack_exp(6, 3, 2, 1'b1, 1'b0, 2, 1, 2'b10));
    do_start(1'b0, 2'b10);
    wait_done(1'b0, 50);

    repeat (5) @(negedge clk);
    chk("exp_a_q_drained", 64'(exp_a_q.size()), 64'd0);
    chk("exp_b_q_drained", 64'(exp_b_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
